mc_lsm_core: RTL and testbench

Parametrised Monte-Carlo American-option pricing core (least-squares style backward induction). It accepts simulated path prices one time-step at a time, from maturity backwards, and keeps a per-path cash-flow memory. It exchanges exercise/cash-flow pairs with an external regression unit over valid/ready handshakes, and finally averages the cash flows into a price. It sits between the path generator and the regression unit, and supports call/put mode and optional per-step discounting.

---
 rtl/mc_lsm_core_if.sv | 33 +++
 rtl/mc_lsm_core.sv | 166 ++++++++++++++++
 tb/tb_mc_lsm_core.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_lsm_core_if.sv
// Handshake bundle between mc_lsm_core, the path generator, the regression unit and the
// price consumer. The master side drives requests and inputs; the core is the slave.
interface mc_lsm_core_if #(
  parameter int W = 12
) ();
  logic         start;
  logic [W-1:0] K;
  logic         put_mode;
  logic [W-1:0] path;
  logic         path_valid;
  logic         path_ready;
  logic [W-1:0] reg_profit;
  logic [W-1:0] reg_cf;
  logic         reg_valid;
  logic         reg_ready;
  logic [W-1:0] cont;
  logic         cont_valid;
  logic         cont_ready;
  logic         busy;
  logic [W-1:0] price;
  logic         price_valid;
  logic         price_ready;

  modport master (
    output start, K, put_mode, path, path_valid, reg_ready, cont, cont_valid, price_ready,
    input  path_ready, reg_profit, reg_cf, reg_valid, cont_ready, busy, price, price_valid
  );

  modport slave (
    input  start, K, put_mode, path, path_valid, reg_ready, cont, cont_valid, price_ready,
    output path_ready, reg_profit, reg_cf, reg_valid, cont_ready, busy, price, price_valid
  );
endinterface

// File: rtl/mc_lsm_core.sv
// Least-squares Monte-Carlo American option core: loads path prices day by day from maturity
// backwards, trades exercise/cash-flow pairs with a regression unit, then averages the cash flows.
module mc_lsm_core #(
  parameter int W          = 12,
  parameter int N          = 128,
  parameter int DAY        = 8,
  parameter int DISC_SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_lsm_core_if.slave bus,
  output logic [2:0]   state_o
);
  localparam int LOG2N = $clog2(N);
  localparam int SW    = W + LOG2N;
  localparam int DW    = (DAY > 1) ? $clog2(DAY) : 1;
  localparam logic [LOG2N:0] LAST_IDX = (LOG2N + 1)'(N - 1);
  localparam logic [LOG2N:0] IDX_ONE  = (LOG2N + 1)'(1);
  localparam logic [DW-1:0]  LAST_DAY = DW'(DAY - 1);
  localparam logic [DW-1:0]  DAY_ONE  = DW'(1);

  // Handshakes: a transfer happens on a rising edge where both valid and ready are high.
  // The core raises a ready/valid purely from its state, never from the partner's signal,
  // and holds reg_valid/price_valid with stable data until the partner accepts.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_REGRESS = 3'd2,
    S_UPDATE  = 3'd3,
    S_AVERAGE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t         state_q;
  logic [LOG2N:0] idx_q;
  logic [LOG2N:0] idx_d;
  logic [DW-1:0]  day_q;
  logic [W-1:0]   k_q;
  logic           put_q;
  logic [SW-1:0]  sum_q;
  logic [SW-1:0]  sum_d;
  logic [W-1:0]   price_q;
  logic [W-1:0]   cf_q [N];
  logic [W-1:0]   ex_q [N];

  logic [LOG2N-1:0] slot;
  logic             last;
  logic [W-1:0]     cf_cur;
  logic [W-1:0]     ex_cur;
  logic [W-1:0]     cf_disc;
  logic [W-1:0]     path_ex;
  logic             take_ex;

  assign slot   = idx_q[LOG2N-1:0];
  assign last   = (idx_q == LAST_IDX);
  assign idx_d  = idx_q + IDX_ONE;
  assign cf_cur = cf_q[slot];
  assign ex_cur = ex_q[slot];
  assign sum_d  = sum_q + SW'(cf_cur);

  // Exercise value is clamped at zero so the unsigned width never wraps.
  always_comb begin
    path_ex = '0;
    if (put_q) begin
      if (k_q > bus.path) path_ex = k_q - bus.path;
    end else begin
      if (bus.path > k_q) path_ex = bus.path - k_q;
    end
  end

  assign cf_disc = (DISC_SHIFT > 0) ? (cf_cur - (cf_cur >> DISC_SHIFT)) : cf_cur;
  assign take_ex = (ex_cur != '0) && (ex_cur > bus.cont);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      day_q   <= '0;
      k_q     <= '0;
      put_q   <= 1'b0;
      sum_q   <= '0;
      price_q <= '0;
      for (int i = 0; i < N; i++) begin
        cf_q[i] <= '0;
        ex_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            day_q   <= '0;
            k_q     <= bus.K;
            put_q   <= bus.put_mode;
            sum_q   <= '0;
          end
        end
        S_LOAD: begin
          if (bus.path_valid) begin
            ex_q[slot] <= path_ex;
            if (day_q == '0) cf_q[slot] <= path_ex;
            if (last) begin
              idx_q <= '0;
              if (DAY == 1)            state_q <= S_AVERAGE;
              else if (day_q == '0)    day_q   <= DAY_ONE;
              else                     state_q <= S_REGRESS;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        S_REGRESS: begin
          if (bus.reg_ready) begin
            if (last) begin
              idx_q   <= '0;
              state_q <= S_UPDATE;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        S_UPDATE: begin
          if (bus.cont_valid) begin
            cf_q[slot] <= take_ex ? ex_cur : cf_disc;
            if (last) begin
              idx_q <= '0;
              if (day_q == LAST_DAY) begin
                state_q <= S_AVERAGE;
              end else begin
                state_q <= S_LOAD;
                day_q   <= day_q + DAY_ONE;
              end
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        S_AVERAGE: begin
          sum_q <= sum_d;
          if (last) begin
            idx_q   <= '0;
            price_q <= sum_d[SW-1:LOG2N];
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_DONE: begin
          if (bus.price_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.path_ready  = (state_q == S_LOAD);
  assign bus.reg_valid   = (state_q == S_REGRESS);
  assign bus.reg_profit  = (state_q == S_REGRESS) ? ex_cur : '0;
  assign bus.reg_cf      = (state_q == S_REGRESS) ? cf_cur : '0;
  assign bus.cont_ready  = (state_q == S_UPDATE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.price       = price_q;
  assign bus.price_valid = (state_q == S_DONE);
  assign state_o         = state_q;
endmodule

// File: tb/tb_mc_lsm_core.sv
// Bench for mc_lsm_core: four configurations share one stimulus bus, selected by sel, and each
// run is checked against hand-worked reg pairs, price and latency.
module tb_mc_lsm_core;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   sel;
  logic         start;
  logic [W-1:0] k;
  logic         put_mode;
  logic [W-1:0] path;
  logic         path_valid;
  logic         reg_ready;
  logic [W-1:0] cont;
  logic         cont_valid;
  logic         price_ready;

  logic [3:0]   o_pr, o_rv, o_cr, o_busy, o_pv;
  logic [W-1:0] o_rp [4];
  logic [W-1:0] o_rc [4];
  logic [W-1:0] o_price [4];
  logic [2:0]   o_st [4];

  logic         path_ready, reg_valid, cont_ready, busy, price_valid;
  logic [W-1:0] reg_profit, reg_cf, price;
  logic [2:0]   st;

  // 0: N4 DAY2 no discount, 1: N4 DAY2 shift 2, 2: N4 DAY1, 3: defaults
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mc_lsm_core_if #(.W(W)) bus ();
    assign bus.start       = start && (sel == 2'(g));
    assign bus.K           = k;
    assign bus.put_mode    = put_mode;
    assign bus.path        = path;
    assign bus.path_valid  = path_valid;
    assign bus.reg_ready   = reg_ready;
    assign bus.cont        = cont;
    assign bus.cont_valid  = cont_valid;
    assign bus.price_ready = price_ready;
    assign o_pr[g]         = bus.path_ready;
    assign o_rv[g]         = bus.reg_valid;
    assign o_cr[g]         = bus.cont_ready;
    assign o_busy[g]       = bus.busy;
    assign o_pv[g]         = bus.price_valid;
    assign o_rp[g]         = bus.reg_profit;
    assign o_rc[g]         = bus.reg_cf;
    assign o_price[g]      = bus.price;

    mc_lsm_core #(
      .W(W),
      .N((g == 3) ? 128 : 4),
      .DAY((g == 2) ? 1 : ((g == 3) ? 8 : 2)),
      .DISC_SHIFT((g == 1) ? 2 : 0)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .state_o(o_st[g])
    );
  end

  assign path_ready  = o_pr[sel];
  assign reg_valid   = o_rv[sel];
  assign cont_ready  = o_cr[sel];
  assign busy        = o_busy[sel];
  assign price_valid = o_pv[sel];
  assign reg_profit  = o_rp[sel];
  assign reg_cf      = o_rc[sel];
  assign price       = o_price[sel];
  assign st          = o_st[sel];

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int             n_checks = 0;
  int             n_fail   = 0;
  int             path_tab[$];
  int             cont_tab[$];
  logic [2*W-1:0] exp_q[$];
  int             exp_price;
  int             exp_latency;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_path_ready"},  path_ready,  0);
    chk({tag, "_reg_valid"},   reg_valid,   0);
    chk({tag, "_reg_profit"},  reg_profit,  0);
    chk({tag, "_reg_cf"},      reg_cf,      0);
    chk({tag, "_cont_ready"},  cont_ready,  0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_price"},       price,       0);
    chk({tag, "_price_valid"}, price_valid, 0);
    chk({tag, "_state"},       st,          0);
  endtask

  task automatic push_pair(input int p, input int c);
    exp_q.push_back({W'(p), W'(c)});
  endtask

  // Call K=100: day0 ex 20,0,30,0; day1 ex 10,0,40,5 -> pairs (ex_day1, cf_day0).
  task automatic setup_a();
    path_tab = '{120, 90, 130, 100, 110, 80, 140, 105};
    cont_tab = '{15, 5, 35, 2};
    exp_q.delete();
    push_pair(10, 20);
    push_pair(0, 0);
    push_pair(40, 30);
    push_pair(5, 0);
  endtask

  // Driver + monitor: inputs change 1 time unit after posedge, outputs sampled on negedge.
  task automatic run_job(input logic [1:0] id, input int kval, input bit put, input bit stall,
                         input int abort_ci, input int budget);
    int             pi = 0;
    int             ci = 0;
    int             cyc = 0;
    int             first_pv = -1;
    bit             got = 0;
    bit             aborted = 0;
    bit             visited_mid = 0;
    bit             path_took = 0;
    bit             cont_took = 0;
    bit             reg_hold = 0;
    bit             price_hold = 0;
    logic [2*W-1:0] held_pair = '0;
    logic [W-1:0]   held_price = '0;
    sel = id;
    k = W'(kval);
    put_mode = put;
    path_valid = 0;
    cont_valid = 0;
    @(posedge clk); #1;
    start = 1;
    while (!got && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = stall && (cyc == 6);
      if (path_took || !path_valid) begin
        path_valid = (pi < path_tab.size()) && (!stall || $urandom_range(0, 3) != 0);
        path = path_valid ? W'(path_tab[pi]) : '0;
      end
      if (cont_took || !cont_valid) begin
        cont_valid = (ci < cont_tab.size()) && (!stall || $urandom_range(0, 3) != 0);
        cont = cont_valid ? W'(cont_tab[ci]) : '0;
      end
      path_took   = 0;
      cont_took   = 0;
      reg_ready   = !stall || ($urandom_range(0, 2) == 0);
      price_ready = !stall || ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (st == 3'd2 || st == 3'd3) visited_mid = 1;
      if (path_valid && path_ready) begin
        pi++;
        path_took = 1;
      end
      if (cont_valid && cont_ready) begin
        ci++;
        cont_took = 1;
      end
      if (reg_valid) begin
        if (reg_hold) chk("reg_stable", {reg_profit, reg_cf}, held_pair);
        if (reg_ready) begin
          if (exp_q.size() == 0) chk("reg_extra", 1, 0);
          else chk("reg_pair", {reg_profit, reg_cf}, exp_q.pop_front());
          reg_hold = 0;
        end else begin
          reg_hold  = 1;
          held_pair = {reg_profit, reg_cf};
        end
      end else begin
        if (reg_hold) chk("reg_valid_held", reg_valid, 1);
        reg_hold = 0;
      end
      if (price_valid) begin
        if (first_pv < 0) first_pv = cyc;
        if (price_hold) chk("price_stable", price, held_price);
        if (price_ready) begin
          chk("price", price, exp_price);
          got = 1;
        end else begin
          price_hold = 1;
          held_price = price;
        end
      end else begin
        if (price_hold) chk("price_valid_held", price_valid, 1);
        price_hold = 0;
      end
      if (abort_ci >= 0 && ci == abort_ci && st == 3'd3) begin
        rst_n = 0;
        #1;
        check_reset("abort");
        aborted = 1;
        start = 0;
        path_valid = 0;
        cont_valid = 0;
        reg_ready = 0;
        price_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        break;
      end
    end
    start = 0;
    if (abort_ci >= 0) begin
      chk("abort_hit", aborted, 1);
      exp_q.delete();
    end else begin
      chk("finished", got, 1);
      if (exp_latency >= 0) chk("latency", first_pv, exp_latency);
      chk("pairs_left", exp_q.size(), 0);
      if (cont_tab.size() == 0) chk("no_mid_states", visited_mid, 0);
      @(posedge clk); #1;
      path_valid = 0;
      cont_valid = 0;
      reg_ready = 0;
      price_ready = 0;
      @(negedge clk);
      chk("pv_drop", price_valid, 0);
      chk("busy_drop", busy, 0);
      chk("price_hold", price, exp_price);
    end
  endtask

  // Main sequence
  initial begin
    rst_n = 0;
    sel = 0;
    start = 0;
    k = '0;
    put_mode = 0;
    path = '0;
    path_valid = 0;
    reg_ready = 0;
    cont = '0;
    cont_valid = 0;
    price_ready = 0;
    exp_price = 0;
    exp_latency = -1;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst_n = 1;

    // Call, K=100: final cf 20,0,40,5 -> 65/4 = 16
    setup_a();
    exp_price = 16;
    exp_latency = 21;
    run_job(2'd0, 100, 0, 0, -1, 400);

    // Discount shift 2: path0 keeps cf 20 -> 15, final 15,0,40,5 -> 60/4 = 15
    setup_a();
    exp_price = 15;
    exp_latency = 21;
    run_job(2'd1, 100, 0, 0, -1, 400);

    // Put, DAY=1: cf 20,0,0,39 -> 59/4 = 14, price_valid at cycle 9
    path_tab = '{80, 120, 100, 61};
    cont_tab.delete();
    exp_q.delete();
    exp_price = 14;
    exp_latency = 9;
    run_job(2'd2, 100, 1, 0, -1, 200);

    // Back-pressure on every handshake plus a start pulse while busy
    setup_a();
    exp_price = 16;
    exp_latency = -1;
    run_job(2'd0, 100, 0, 1, -1, 2000);

    // Defaults: every path 4095 with K=0, cont 0 -> price 4095 at cycle 2945
    path_tab.delete();
    cont_tab.delete();
    exp_q.delete();
    for (int i = 0; i < 128 * 8; i++) path_tab.push_back(4095);
    for (int i = 0; i < 128 * 7; i++) begin
      cont_tab.push_back(0);
      push_pair(4095, 4095);
    end
    exp_price = 4095;
    exp_latency = 2945;
    run_job(2'd3, 0, 0, 0, -1, 5000);

    // Reset in the middle of the day-1 UPDATE, then a clean rerun
    setup_a();
    exp_price = 16;
    exp_latency = 21;
    run_job(2'd0, 100, 0, 0, 2, 400);
    setup_a();
    exp_price = 16;
    exp_latency = 21;
    run_job(2'd0, 100, 0, 0, -1, 400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
